posit_extract_arbiter: RTL
==========================

// Module: posit_extract_arbiter
// PURPOSE
//  Shares one posit_extract_raw datapath (ES=2) between NREQ requesters.
//  - Round-robin arbiter grants at most one request per cycle.
//  - The granted posit passes through a 2-stage valid/ready pipeline.
//  - Result leaves tagged with the requester index.
//  - Sits between posit operand sources (adder/multiplier operand ports)
//    and the arithmetic cores.
// PARAMETERS
//  NREQ  4  number of requesters, 2..8
//  IDW   2  requester index width, $clog2(NREQ)
//  (NBITS, ES, POSIT_SERIALIZED_WIDTH_ES2 come from posit_defines)
// PORTS
//  clk           in   1                          rising-edge clock
//  reset         in   1                          synchronous, active-high
//  req_valid     in   NREQ                       request i holds a posit
//  req_ready     out  NREQ                       request i accepted this cycle
//  req_data      in   NREQ*NBITS                 posit i at [i*NBITS +: NBITS]
//  flush         in   1                          discard all in-flight entries
//  out_valid     out  1                          result valid
//  out_ready     in   1                          consumer accepts result
//  out_id        out  IDW                        index of originating requester
//  out_result    out  POSIT_SERIALIZED_WIDTH_ES2 {sgn,scale,fraction,inf,zero}
//  out_absolute  out  NBITS-1                    |posit| without sign bit
//  busy          out  1                          any pipeline stage valid
// BEHAVIOUR
//  Reset values: all outputs 0, both stage valids 0, rr_ptr 0.
//  Pipeline stages:
//  - S1 holds {posit, id}; feeds posit_extract_raw combinationally.
//  - S2 registers {result, absolute, id}; drives the out_* ports.
//  Advance rules:
//  - s2_adv = !s2_v | out_ready
//  - s1_adv = !s1_v | s2_adv
//  - grant allowed only when s1_adv & !flush
//  Arbitration:
//  - Search starts at rr_ptr, wraps modulo NREQ; first i with req_valid[i]
//    wins; req_ready is one-hot or zero.
//  - On grant to i: rr_ptr <= (i==NREQ-1) ? 0 : i+1. With no grant, rr_ptr holds.
//  - req_ready is combinational from req_valid and may depend on it.
//    req_valid must not depend on req_ready.
//  Latency: accepted at edge t -> out_valid from edge t+1 (S1) to edge t+2 (S2)
//   when unstalled. Throughput 1 per cycle.
//  Stall: out_valid & !out_ready holds out_* bit-stable. If S1 is also full,
//   req_ready is all 0.
//  flush: at the next edge s1_v and s2_v go to 0; no grant that cycle;
//   rr_ptr unchanged. An asserted req_valid remains pending.
//  reset mid-operation: same as flush, and rr_ptr goes to 0.
//  Width rules: out_result is bit-exact with posit_extract_raw on the captured
//   posit. 0x00000000 gives zero=1; 0x80000000 gives inf=1.
//  No FSM. Control state is only s1_v, s2_v and rr_ptr.
// CONFIGURATION
//  ARB_STATS_EN defined:
//  - Adds output grant_cnt [NREQ*16], per-requester saturating grant counters.
//  - Counters clear on reset only (not on flush) and saturate at 16'hFFFF.
//  ARB_STATS_EN undefined: grant_cnt port and counters are absent; all other
//   behaviour is identical.
// STRUCTURE
//  posit_defines gains:
//  - typedef arb_id_t (logic [IDW-1:0])
//  - typedef struct packed {logic [NBITS-1:0] posit; arb_id_t id;} extract_req_t
//  - localparam ARB_CNT_W = 16
//  Sub-module: rr_arbiter #(.N(NREQ)) (req, en, gnt, gnt_idx; owns rr_ptr).
//   The single posit_extract_raw instance lives in this module.
// TESTING
//  1. Reset, all idle -> out_valid=0, busy=0, req_ready=0.
//  2. Only req1 valid, data 0x40000000, out_ready=1 -> req_ready[1]=1 at t;
//     out_valid at t+2 with out_id=1, sgn=0, scale=0, zero=0, inf=0.
//  3. All 4 valid continuously, out_ready=1 -> grant order 0,1,2,3,0,...;
//     out_id sequence matches, one result per cycle.
//  4. out_ready=0 for 5 cycles with both stages full -> req_ready=0 and out_*
//     stable throughout; after release, ids come out in order with no loss
//     or duplicate.
//  5. flush with s1_v=s2_v=1 and req0 valid -> next cycle busy=0, no grant
//     that cycle; req0 granted the cycle after.
//  6. Inputs 0x00000000, 0x80000000, 0xFFFFFFFF -> zero=1, inf=1, and sgn=1
//     with out_absolute=0x0000001 respectively.

Source files
------------

// File: rtl/posit_extract_arbiter_pkg.sv
// posit_extract_arbiter_pkg: posit widths, arbiter typedefs and the leading-zero helper.
package posit_extract_arbiter_pkg;
   localparam int NBITS = 32;
   localparam int ES = 2;
   localparam int ARB_NREQ = 4;
   localparam int ARB_IDW = $clog2(ARB_NREQ);
   localparam int SCALE_W = 6 + ES;
   localparam int FRAC_W = NBITS - 3 - ES;
   localparam int POSIT_SERIALIZED_WIDTH_ES2 = 1 + SCALE_W + FRAC_W + 2;
   localparam int ARB_CNT_W = 16;
   typedef logic [ARB_IDW-1:0] arb_id_t;
   typedef struct packed {logic [NBITS-1:0] posit; arb_id_t id;} extract_req_t;
   function automatic logic [5:0] lead_zeros(input logic [NBITS-2:0] x);
      lead_zeros = 6'(NBITS - 1);
      for (int i = 0; i < NBITS - 1; i++)
         if (x[i]) lead_zeros = 6'(NBITS - 2 - i);
   endfunction
endpackage

// File: rtl/posit_extract_arbiter_raw.sv
// posit_extract_raw: combinational ES=2 posit decode into {sgn,scale,fraction,inf,zero}.
module posit_extract_raw
   import posit_extract_arbiter_pkg::*;
(
   input  logic [NBITS-1:0]                      posit,
   output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] result,
   output logic [NBITS-2:0]                      absolute
);
   logic sgn, zero, inf;
   logic [5:0] run, k;
   logic [NBITS-2:0] tail;
   always_comb begin
      sgn = posit[NBITS-1];
      absolute = (posit[NBITS-2:0] ^ {(NBITS-1){sgn}}) + (NBITS-1)'(sgn);
      zero = posit == '0;
      inf = sgn & (posit[NBITS-2:0] == '0);
      run = lead_zeros(absolute[NBITS-2] ? ~absolute : absolute);
      k = absolute[NBITS-2] ? run - 6'd1 : -run;
      // drop regime run and its terminator; exponent then fraction are left-aligned
      tail = absolute << (run + 6'd1);
      result = (zero | inf) ? {sgn, (SCALE_W + FRAC_W)'(0), inf, zero}
                            : {sgn, k, tail[NBITS-2 -: ES], FRAC_W'(tail[NBITS-ES-2:0] >> ES), 2'b00};
   end
endmodule

// File: rtl/posit_extract_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant starting at rr_ptr, pointer moves past each winner.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   logic [IW-1:0] rr_ptr;
   logic found;
   always_comb begin
      found = 1'b0;
      gnt_idx = '0;
      for (int o = 0; o < N; o++)
         if (!found && req[IW'((int'(rr_ptr) + o) % N)]) begin
            found = 1'b1;
            gnt_idx = IW'((int'(rr_ptr) + o) % N);
         end
      gnt = (found && en) ? N'(1) << gnt_idx : '0;
   end
   always_ff @(posedge clk)
      if (reset) rr_ptr <= '0;
      else if (|gnt) rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
endmodule

// File: rtl/posit_extract_arbiter.sv
// posit_extract_arbiter: round-robin sharing of one posit_extract_raw over a 2-stage valid/ready pipe.
// Define ARB_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module posit_extract_arbiter
   import posit_extract_arbiter_pkg::*;
#(
   parameter int NREQ = ARB_NREQ,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NREQ-1:0]                       req_valid,
   output logic [NREQ-1:0]                       req_ready,
   input  logic [NREQ*NBITS-1:0]                 req_data,
   input  logic                                  flush,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [IDW-1:0]                        out_id,
   output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_result,
   output logic [NBITS-2:0]                      out_absolute,
   output logic                                  busy
`ifdef ARB_STATS_EN
   ,output logic [NREQ*ARB_CNT_W-1:0]            grant_cnt
`endif
);
   logic s1_v, s2_v, s1_adv, s2_adv, grant_en;
   logic [NBITS-1:0] s1_posit;
   logic [IDW-1:0] s1_id, gnt_idx;
   logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] raw_result;
   logic [NBITS-2:0] raw_abs;
   assign s2_adv = !s2_v || out_ready;
   assign s1_adv = !s1_v || s2_adv;
   assign grant_en = s1_adv && !flush && !reset;
   assign out_valid = s2_v;
   assign busy = s1_v || s2_v;
   rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
      .clk(clk), .reset(reset), .req(req_valid), .en(grant_en), .gnt(req_ready), .gnt_idx(gnt_idx)
   );
   posit_extract_raw u_raw (.posit(s1_posit), .result(raw_result), .absolute(raw_abs));
   always_ff @(posedge clk)
      if (reset || flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (s1_adv) s1_v <= |req_ready;
         if (s2_adv) s2_v <= s1_v;
      end
   // payload loads only with a valid entry so stalled or idle outputs stay put
   always_ff @(posedge clk)
      if (reset) begin
         s1_posit <= '0;
         s1_id <= '0;
         out_id <= '0;
         out_result <= '0;
         out_absolute <= '0;
      end else begin
         if (s1_adv && |req_ready) begin
            s1_posit <= req_data[gnt_idx*NBITS +: NBITS];
            s1_id <= gnt_idx;
         end
         if (s2_adv && s1_v) begin
            out_id <= s1_id;
            out_result <= raw_result;
            out_absolute <= raw_abs;
         end
      end
`ifdef ARB_STATS_EN
   logic [ARB_CNT_W-1:0] cnt [NREQ];
   always_ff @(posedge clk)
      for (int i = 0; i < NREQ; i++)
         if (reset) cnt[i] <= '0;
         else if (req_ready[i] && cnt[i] != '1) cnt[i] <= cnt[i] + ARB_CNT_W'(1);
   for (genvar i = 0; i < NREQ; i++) begin : g_cnt
      assign grant_cnt[i*ARB_CNT_W +: ARB_CNT_W] = cnt[i];
   end
`endif
endmodule
